// File: rtl/wb_io_bridge_msi.sv
// CPU-side Wishbone 256-bit slave bridged to CHANNELS devices: registered request broadcast,
// registered response with bus timeout, and per-channel MSI FIFOs drained round-robin when idle.

package wishbone_pkg;
  typedef enum logic [1:0] {OKAY = 2'd0, ERR = 2'd1, IRQ = 2'd2, RTY_ERR = 2'd3} wb_err_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [2:0]   cti;
    logic [7:0]   tid;
    logic [31:0]  sel;
    logic [31:0]  adr;
    logic [255:0] dat;
  } wb_cmd_request256_t;

  typedef struct packed {
    logic         ack;
    logic         stall;
    logic         next;
    logic         rty;
    wb_err_t      err;
    logic [3:0]   pri;
    logic [7:0]   tid;
    logic [255:0] dat;
  } wb_cmd_response256_t;
endpackage

module wb_io_bridge_msi_irq_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 264
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         nonempty,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, do_push;

  assign nonempty = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || pop);
  assign ovf      = push && full && !pop;
  assign rdata    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop && nonempty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module wb_io_bridge_msi #(
  parameter int         CHANNELS  = 2,
  parameter int         IRQ_DEPTH = 16,
  parameter int         TO_CYCLES = 1023,
  parameter logic [3:0] IRQ_PRI   = 4'd8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  wishbone_pkg::wb_cmd_request256_t   s1_req,
  output wishbone_pkg::wb_cmd_response256_t  s1_resp,
  output wishbone_pkg::wb_cmd_request256_t   m_req,
  input  wishbone_pkg::wb_cmd_response256_t  chresp [CHANNELS],
  output logic [CHANNELS-1:0]                irq_ovf_o,
  input  logic                               irq_ovf_clr_i,
  output logic                               irq_pending_o
);
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
  localparam int FW    = 264;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t                           state, state_nx;
  wishbone_pkg::wb_cmd_response256_t resp_nx;
  logic [CNT_W-1:0]                 to_cnt, cnt_nx;
  logic [CW-1:0]                    rr_ptr, bus_idx, irq_idx;
  logic                             req_go, bus_hit, irq_hit, to_hit, drain;
  logic [CHANNELS-1:0]              push, pop, nonempty, ovf_set;
  logic [FW-1:0]                    fifo_rd [CHANNELS];
  logic [FW-1:0]                    irq_ent;

  assign req_go        = s1_req.cyc & s1_req.stb;
  assign irq_pending_o = |nonempty;
  assign to_hit        = (TO_CYCLES != 0) && (to_cnt == CNT_W'(TO_CYCLES));
  assign irq_ent       = fifo_rd[irq_idx];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign push[g] = chresp[g].ack && (chresp[g].err == wishbone_pkg::IRQ);
    assign pop[g]  = drain && (irq_idx == CW'(g));

    wb_io_bridge_msi_irq_fifo #(.DEPTH(IRQ_DEPTH), .W(FW)) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push     (push[g]),
      .pop      (pop[g]),
      .wdata    ({chresp[g].tid, chresp[g].dat}),
      .rdata    (fifo_rd[g]),
      .nonempty (nonempty[g]),
      .ovf      (ovf_set[g])
    );
  end

  // Lowest-index non-IRQ ack wins the bus response.
  always_comb begin
    bus_hit = 1'b0;
    bus_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (chresp[i].ack && (chresp[i].err != wishbone_pkg::IRQ)) begin
        bus_hit = 1'b1;
        bus_idx = CW'(i);
      end
    end
    bus_hit = bus_hit & req_go;
  end

  always_comb begin
    int j;
    j       = 0;
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!irq_hit && nonempty[CW'(j)]) begin
        irq_hit = 1'b1;
        irq_idx = CW'(j);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_go) state_nx = WAIT;
      WAIT:    if (!req_go) state_nx = IDLE;
               else if (bus_hit || to_hit) state_nx = HOLD;
      HOLD:    if (!s1_req.stb) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    resp_nx = s1_resp;
    cnt_nx  = to_cnt;
    drain   = 1'b0;
    case (state)
      IDLE: begin
        resp_nx = '0;
        cnt_nx  = '0;
        // The ack=0 gate guarantees a dead cycle between successive IRQ responses.
        if (!req_go && !s1_resp.ack && irq_hit) begin
          drain       = 1'b1;
          resp_nx.ack = 1'b1;
          resp_nx.err = wishbone_pkg::IRQ;
          resp_nx.pri = IRQ_PRI;
          resp_nx.tid = irq_ent[263:256];
          resp_nx.dat = irq_ent[255:0];
        end
      end
      WAIT: begin
        if (!req_go) begin
          resp_nx = '0;
        end else if (bus_hit) begin
          resp_nx     = chresp[bus_idx];
          resp_nx.ack = 1'b1;
        end else if (to_hit) begin
          resp_nx     = '0;
          resp_nx.ack = 1'b1;
          resp_nx.err = wishbone_pkg::ERR;
          resp_nx.tid = s1_req.tid;
        end else if (TO_CYCLES != 0) begin
          cnt_nx = to_cnt + CNT_W'(1);
        end
      end
      HOLD:    if (!s1_req.stb) resp_nx = '0;
      default: resp_nx = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_resp   <= '0;
      to_cnt    <= '0;
      rr_ptr    <= '0;
      irq_ovf_o <= '0;
    end else begin
      s1_resp   <= resp_nx;
      to_cnt    <= cnt_nx;
      irq_ovf_o <= (irq_ovf_o & ~{CHANNELS{irq_ovf_clr_i}}) | ovf_set;
      if (drain) rr_ptr <= (irq_idx == CW'(CHANNELS - 1)) ? '0 : irq_idx + CW'(1);
    end
  end

  // Idle request parks on an unmapped address; tid/cti keep their last value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_req     <= '0;
      m_req.adr <= '1;
    end else if (s1_req.cyc) begin
      m_req <= s1_req;
    end else begin
      m_req.cyc <= 1'b0;
      m_req.stb <= 1'b0;
      m_req.we  <= 1'b0;
      m_req.sel <= '0;
      m_req.adr <= '1;
      m_req.dat <= '0;
    end
  end
endmodule

// File: tb/tb_wb_io_bridge_msi.sv
// Directed bench for wb_io_bridge_msi: read, timeout, round-robin IRQ drain, overflow,
// bus/IRQ contention and reset mid-transfer, with hand-computed expectations.
module tb_wb_io_bridge_msi;
  import wishbone_pkg::*;

  localparam int CH = 4;

  logic                clk = 1'b0;
  logic                rst;
  wb_cmd_request256_t  s1_req, m_req;
  wb_cmd_response256_t s1_resp;
  wb_cmd_response256_t chresp [CH];
  logic [CH-1:0]       irq_ovf;
  logic                ovf_clr, irq_pending;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  wb_io_bridge_msi #(.CHANNELS(CH), .IRQ_DEPTH(2), .TO_CYCLES(8), .IRQ_PRI(4'd8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .s1_req        (s1_req),
    .s1_resp       (s1_resp),
    .m_req         (m_req),
    .chresp        (chresp),
    .irq_ovf_o     (irq_ovf),
    .irq_ovf_clr_i (ovf_clr),
    .irq_pending_o (irq_pending)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ch;
    for (int i = 0; i < CH; i++) chresp[i] = '0;
  endtask

  task automatic irq_push(input int ch, input logic [7:0] tid);
    chresp[ch].ack = 1'b1;
    chresp[ch].err = wishbone_pkg::IRQ;
    chresp[ch].tid = tid;
    chresp[ch].dat = {32{tid}};
  endtask

  task automatic test_reset;
    s1_req = '0; clr_ch(); ovf_clr = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    vec++; if (s1_resp !== '0) begin miss++; $display("FAIL rst_resp got %h exp 0", s1_resp); end
    vec++; if (m_req.adr !== 32'hFFFF_FFFF) begin miss++; $display("FAIL rst_madr got %h exp ffffffff", m_req.adr); end
    vec++; if (m_req.cyc !== 1'b0) begin miss++; $display("FAIL rst_mcyc got %b exp 0", m_req.cyc); end
    vec++; if (irq_ovf !== 4'b0) begin miss++; $display("FAIL rst_ovf got %b exp 0000", irq_ovf); end
    vec++; if (irq_pending !== 1'b0) begin miss++; $display("FAIL rst_pend got %b exp 0", irq_pending); end
  endtask

  task automatic test_read;
    logic [255:0] a5, wd;
    a5 = {32{8'hA5}};
    wd = {8{32'hDEAD_BEEF}};
    s1_req = '0; s1_req.cyc = 1; s1_req.stb = 1; s1_req.adr = 32'h0000_1000;
    s1_req.tid = 8'd3; s1_req.sel = '1; s1_req.dat = wd;
    tick();
    vec++; if (m_req.adr !== 32'h1000) begin miss++; $display("FAIL rd_madr got %h exp 1000", m_req.adr); end
    vec++; if (m_req.dat !== wd) begin miss++; $display("FAIL rd_mdat got %h exp %h", m_req.dat, wd); end
    vec++; if (s1_resp.ack !== 1'b0) begin miss++; $display("FAIL rd_early got %b exp 0", s1_resp.ack); end
    tick();
    chresp[1].ack = 1; chresp[1].err = wishbone_pkg::OKAY; chresp[1].tid = 8'd5; chresp[1].dat = a5;
    tick();
    clr_ch();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.tid !== 8'd5) begin miss++; $display("FAIL rd_ack got ack=%b tid=%0d exp ack=1 tid=5", s1_resp.ack, s1_resp.tid); end
    vec++; if (s1_resp.dat !== a5 || s1_resp.err !== wishbone_pkg::OKAY) begin miss++; $display("FAIL rd_dat got %h err=%0d exp %h err=0", s1_resp.dat, s1_resp.err, a5); end
    tick();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.dat !== a5) begin miss++; $display("FAIL rd_hold got ack=%b exp ack=1", s1_resp.ack); end
    s1_req.cyc = 0; s1_req.stb = 0;
    tick();
    vec++; if (s1_resp !== '0) begin miss++; $display("FAIL rd_zero got %h exp 0", s1_resp); end
    vec++; if (m_req.adr !== 32'hFFFF_FFFF || m_req.dat !== '0) begin miss++; $display("FAIL rd_midle got adr=%h exp ffffffff dat=0", m_req.adr); end
    vec++; if (m_req.tid !== 8'd3) begin miss++; $display("FAIL rd_mtid got %0d exp 3", m_req.tid); end
  endtask

  task automatic test_timeout;
    logic seen;
    s1_req = '0; s1_req.cyc = 1; s1_req.stb = 1; s1_req.adr = 32'h2000; s1_req.tid = 8'd7;
    tick();
    seen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (s1_resp.ack) seen = 1'b1;
    end
    vec++; if (seen !== 1'b0) begin miss++; $display("FAIL to_early got ack before cycle 9 exp none"); end
    tick();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.err !== wishbone_pkg::ERR) begin miss++; $display("FAIL to_ack got ack=%b err=%0d exp ack=1 err=1", s1_resp.ack, s1_resp.err); end
    vec++; if (s1_resp.dat !== '0 || s1_resp.tid !== 8'd7) begin miss++; $display("FAIL to_dat got tid=%0d exp dat=0 tid=7", s1_resp.tid); end
    s1_req.cyc = 0; s1_req.stb = 0;
    tick();
    vec++; if (s1_resp !== '0) begin miss++; $display("FAIL to_zero got %h exp 0", s1_resp); end
  endtask

  task automatic test_round_robin;
    irq_push(0, 8'd10); irq_push(2, 8'd12); irq_push(3, 8'd13);
    tick();
    clr_ch();
    vec++; if (irq_pending !== 1'b1 || s1_resp.ack !== 1'b0) begin miss++; $display("FAIL rr_push got pend=%b ack=%b exp pend=1 ack=0", irq_pending, s1_resp.ack); end
    tick();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.tid !== 8'd10 || s1_resp.err !== wishbone_pkg::IRQ) begin miss++; $display("FAIL rr_first got ack=%b tid=%0d exp ack=1 tid=10", s1_resp.ack, s1_resp.tid); end
    vec++; if (s1_resp.pri !== 4'd8 || s1_resp.dat !== {32{8'd10}}) begin miss++; $display("FAIL rr_pri got pri=%0d exp 8", s1_resp.pri); end
    tick();
    vec++; if (s1_resp.ack !== 1'b0) begin miss++; $display("FAIL rr_gap got %b exp 0", s1_resp.ack); end
    tick();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.tid !== 8'd12 || s1_resp.pri !== 4'd8) begin miss++; $display("FAIL rr_second got ack=%b tid=%0d exp ack=1 tid=12", s1_resp.ack, s1_resp.tid); end
    vec++; if (irq_pending !== 1'b1) begin miss++; $display("FAIL rr_pend2 got %b exp 1", irq_pending); end
    tick();
    tick();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.tid !== 8'd13) begin miss++; $display("FAIL rr_third got ack=%b tid=%0d exp ack=1 tid=13", s1_resp.ack, s1_resp.tid); end
    vec++; if (irq_pending !== 1'b0) begin miss++; $display("FAIL rr_pend3 got %b exp 0", irq_pending); end
    tick();
    vec++; if (s1_resp.ack !== 1'b0) begin miss++; $display("FAIL rr_end got %b exp 0", s1_resp.ack); end
  endtask

  task automatic test_overflow;
    s1_req = '0; s1_req.cyc = 1; s1_req.stb = 1; s1_req.adr = 32'h3000;
    tick();
    irq_push(1, 8'd21); tick();
    irq_push(1, 8'd22); tick();
    vec++; if (irq_ovf !== 4'b0000) begin miss++; $display("FAIL ovf_none got %b exp 0000", irq_ovf); end
    irq_push(1, 8'd23); tick();
    clr_ch();
    vec++; if (irq_ovf !== 4'b0010) begin miss++; $display("FAIL ovf_set got %b exp 0010", irq_ovf); end
    vec++; if (s1_resp.ack !== 1'b0) begin miss++; $display("FAIL ovf_nodrain got %b exp 0", s1_resp.ack); end
    s1_req.cyc = 0; s1_req.stb = 0;
    tick();
    vec++; if (s1_resp !== '0) begin miss++; $display("FAIL ovf_drop got %h exp 0", s1_resp); end
    tick();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.tid !== 8'd21) begin miss++; $display("FAIL ovf_irq1 got ack=%b tid=%0d exp ack=1 tid=21", s1_resp.ack, s1_resp.tid); end
    tick(); tick();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.tid !== 8'd22) begin miss++; $display("FAIL ovf_irq2 got ack=%b tid=%0d exp ack=1 tid=22", s1_resp.ack, s1_resp.tid); end
    tick(); tick();
    vec++; if (s1_resp.ack !== 1'b0 || irq_pending !== 1'b0) begin miss++; $display("FAIL ovf_irq3 got ack=%b pend=%b exp 0 0", s1_resp.ack, irq_pending); end
    vec++; if (irq_ovf !== 4'b0010) begin miss++; $display("FAIL ovf_sticky got %b exp 0010", irq_ovf); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    vec++; if (irq_ovf !== 4'b0000) begin miss++; $display("FAIL ovf_clr got %b exp 0000", irq_ovf); end
  endtask

  task automatic test_contention;
    s1_req = '0; s1_req.cyc = 1; s1_req.stb = 1; s1_req.adr = 32'h4000;
    tick();
    irq_push(0, 8'd30);
    chresp[1].ack = 1; chresp[1].err = wishbone_pkg::OKAY; chresp[1].tid = 8'd31; chresp[1].dat = 256'h1234;
    tick();
    clr_ch();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.tid !== 8'd31 || s1_resp.dat !== 256'h1234) begin miss++; $display("FAIL ct_bus got ack=%b tid=%0d exp ack=1 tid=31", s1_resp.ack, s1_resp.tid); end
    vec++; if (irq_pending !== 1'b1) begin miss++; $display("FAIL ct_pend got %b exp 1", irq_pending); end
    tick();
    vec++; if (s1_resp.tid !== 8'd31 || s1_resp.ack !== 1'b1) begin miss++; $display("FAIL ct_hold got tid=%0d exp 31", s1_resp.tid); end
    s1_req.cyc = 0; s1_req.stb = 0;
    tick();
    vec++; if (s1_resp.ack !== 1'b0) begin miss++; $display("FAIL ct_gap got %b exp 0", s1_resp.ack); end
    tick();
    vec++; if (s1_resp.ack !== 1'b1 || s1_resp.tid !== 8'd30 || s1_resp.err !== wishbone_pkg::IRQ) begin miss++; $display("FAIL ct_irq got ack=%b tid=%0d exp ack=1 tid=30", s1_resp.ack, s1_resp.tid); end
    tick();
  endtask

  task automatic test_reset_mid;
    s1_req = '0; s1_req.cyc = 1; s1_req.stb = 1; s1_req.adr = 32'h5000;
    irq_push(0, 8'd40); irq_push(1, 8'd41); irq_push(2, 8'd42);
    tick();
    clr_ch();
    vec++; if (irq_pending !== 1'b1 || s1_resp.ack !== 1'b0) begin miss++; $display("FAIL rm_pre got pend=%b ack=%b exp 1 0", irq_pending, s1_resp.ack); end
    tick();
    rst = 1'b1;
    tick();
    vec++; if (s1_resp !== '0 || irq_pending !== 1'b0) begin miss++; $display("FAIL rm_rst got pend=%b exp resp=0 pend=0", irq_pending); end
    vec++; if (m_req.adr !== 32'hFFFF_FFFF) begin miss++; $display("FAIL rm_madr got %h exp ffffffff", m_req.adr); end
    rst = 1'b0; s1_req = '0;
    tick();
    vec++; if (s1_resp !== '0 || irq_pending !== 1'b0 || m_req.adr !== 32'hFFFF_FFFF) begin miss++; $display("FAIL rm_post got ack=%b pend=%b adr=%h exp 0 0 ffffffff", s1_resp.ack, irq_pending, m_req.adr); end
    tick();
    vec++; if (s1_resp.ack !== 1'b0) begin miss++; $display("FAIL rm_nodrain got %b exp 0", s1_resp.ack); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_timeout();
    test_round_robin();
    test_overflow();
    test_contention();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
